// File: rtl/pulse_tick_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pulse_tick_gen : programmable periodic / one-shot pulse generator with a
//                  Gray-coded count of emitted pulses.          Revision 1.0
// -----------------------------------------------------------------------------
module pulse_tick_gen #(
  parameter int CNT_W          = 27,
  parameter int DEFAULT_PERIOD = 100000000,
  parameter int PW_W           = 4,
  parameter int TICK_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic              period_ld,
  input  logic [CNT_W-1:0]  period_in,
  input  logic [PW_W-1:0]   width_in,
  output logic              pulse,
  output logic              busy,
  output logic [TICK_W-1:0] tick_gray
);

  localparam int               XW    = (CNT_W > PW_W) ? CNT_W : PW_W;
  localparam logic [CNT_W-1:0] P_RST = CNT_W'(DEFAULT_PERIOD);
  localparam logic [PW_W-1:0]  W_RST = PW_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]    period_act, period_sh, period_sh_nxt, period_ld_val;
  logic [PW_W-1:0]     width_act, width_sh, width_sh_nxt, width_ld_val;
  logic [TICK_W-1:0]   tick_bin, tick_bin_nxt;
  logic                pulse_nxt, tick_inc, apply_shadow;
  logic                period_end, width_end;

  always_comb begin
    period_ld_val = (period_in == '0) ? CNT_W'(1) : period_in;
    width_ld_val  = (width_in == '0) ? PW_W'(1) : width_in;
    period_sh_nxt = period_ld ? period_ld_val : period_sh;
    width_sh_nxt  = period_ld ? width_ld_val : width_sh;

    cnt_inc    = cnt + CNT_W'(1);
    period_end = (cnt == period_act - CNT_W'(1));
    width_end  = (XW'(cnt) == XW'(width_act) - XW'(1));

    state_nxt    = state;
    cnt_nxt      = '0;
    pulse_nxt    = 1'b0;
    tick_inc     = 1'b0;
    apply_shadow = 1'b0;

    case (state)
      IDLE: begin
        // Shadow values (including a load on this very edge) become active here.
        apply_shadow = 1'b1;
        if (en && !mode) begin
          state_nxt = RUN;
          pulse_nxt = 1'b1;
          tick_inc  = 1'b1;
        end else if (en && mode && start) begin
          state_nxt = DELAY;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (period_end) begin
          apply_shadow = 1'b1;
          pulse_nxt    = 1'b1;
          tick_inc     = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
          pulse_nxt = (XW'(cnt_inc) < XW'(width_act));
        end
      end
      DELAY: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (period_end) begin
          state_nxt = PULSE;
          pulse_nxt = 1'b1;
          tick_inc  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PULSE: begin
        if (!en || width_end) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt_inc;
          pulse_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    tick_bin_nxt = tick_bin + TICK_W'(tick_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pulse      <= 1'b0;
      busy       <= 1'b0;
      tick_bin   <= '0;
      tick_gray  <= '0;
      period_act <= P_RST;
      width_act  <= W_RST;
      period_sh  <= P_RST;
      width_sh   <= W_RST;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse     <= pulse_nxt;
      busy      <= (state_nxt != IDLE);
      tick_bin  <= tick_bin_nxt;
      tick_gray <= tick_bin_nxt ^ (tick_bin_nxt >> 1);
      period_sh <= period_sh_nxt;
      width_sh  <= width_sh_nxt;
      if (apply_shadow) begin
        period_act <= period_sh_nxt;
        width_act  <= width_sh_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_tick_gen.sv
`default_nettype none
// Testbench for pulse_tick_gen: directed vector table, hand-written corner
// sequences and randomized stimulus against a time-based reference model.
module tb_pulse_tick_gen;

  localparam int CNT_W  = 8;
  localparam int DEF_P  = 5;
  localparam int PW_W   = 4;
  localparam int TICK_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0, mode = 1'b0, start = 1'b0, period_ld = 1'b0;
  logic [CNT_W-1:0]  period_in = '0;
  logic [PW_W-1:0]   width_in = '0;
  logic              pulse, busy;
  logic [TICK_W-1:0] tick_gray;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_tick_gen #(
    .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .PW_W(PW_W), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .period_ld(period_ld), .period_in(period_in), .width_in(width_in),
    .pulse(pulse), .busy(busy), .tick_gray(tick_gray)
  );

  typedef struct {
    logic e, m, s, l;
    int   p, w;
    logic pu, bu;
    int   g;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gray(input int b);
    int x;
    x = b % (1 << TICK_W);
    return x ^ (x >> 1);
  endfunction

  task automatic drive(input logic e, input logic m, input logic s, input logic l,
                       input int p, input int w);
    en = e; mode = m; start = s; period_ld = l;
    period_in = CNT_W'(p); width_in = PW_W'(w);
  endtask

  task automatic v(input logic e, input logic m, input logic s, input logic l,
                   input int p, input int w, input logic pu, input logic bu, input int g);
    vec_t r;
    r.e = e; r.m = m; r.s = s; r.l = l; r.p = p; r.w = w; r.pu = pu; r.bu = bu; r.g = g;
    tbl.push_back(r);
  endtask

  // Reference model: time-stamped segments rather than a cycle counter.
  int m_state, t, seg_start, seg_p, seg_w, trig, os_p, os_w;
  int sh_p, sh_w, act_p, act_w, m_tick;

  task automatic model_reset();
    m_state = 0; t = 0; m_tick = 0;
    sh_p = DEF_P; sh_w = 1; act_p = DEF_P; act_w = 1;
    seg_start = 0; seg_p = DEF_P; seg_w = 1; trig = 0; os_p = 0; os_w = 0;
  endtask

  task automatic model_edge(input logic e, input logic m, input logic s, input logic l,
                            input int pin, input int win);
    t++;
    if (l) begin
      sh_p = (pin == 0) ? 1 : pin;
      sh_w = (win == 0) ? 1 : win;
    end
    case (m_state)
      0: begin
        act_p = sh_p; act_w = sh_w;
        if (e && !m) begin
          m_state = 1; seg_start = t; seg_p = act_p; seg_w = act_w; m_tick++;
        end else if (e && m && s) begin
          m_state = 2; trig = t; os_p = act_p; os_w = act_w;
        end
      end
      1: begin
        if (!e) m_state = 0;
        else if (t - seg_start == seg_p) begin
          act_p = sh_p; act_w = sh_w;
          seg_start = t; seg_p = act_p; seg_w = act_w; m_tick++;
        end
      end
      default: begin
        if (!e) m_state = 0;
        else if (t == trig + os_p) m_tick++;
        else if (t == trig + os_p + os_w) m_state = 0;
      end
    endcase
  endtask

  function automatic logic exp_pulse();
    if (m_state == 1) return (t - seg_start) < seg_w;
    if (m_state == 2) return t >= trig + os_p;
    return 1'b0;
  endfunction

  initial begin
    int prev_g;
    model_reset();

    // Row i is applied before edge i; expectations hold after edge i.
    v(1,0,0,0,0,0, 1,1,1);
    for (int i = 1; i <= 4; i++) v(1,0,0,0,0,0, 0,1,1);
    v(1,0,0,0,0,0, 1,1,3);
    for (int i = 6; i <= 9; i++) v(1,0,0,0,0,0, 0,1,3);
    v(1,0,0,0,0,0, 1,1,2);
    v(0,0,0,0,0,0, 0,0,2);
    v(0,0,0,1,3,2, 0,0,2);
    v(1,0,0,0,0,0, 1,1,6);
    v(1,0,0,0,0,0, 1,1,6);
    v(1,0,0,0,0,0, 0,1,6);
    v(1,0,0,0,0,0, 1,1,7);
    v(1,0,0,1,3,5, 1,1,7);
    v(1,0,0,0,0,0, 0,1,7);
    v(1,0,0,0,0,0, 1,1,5);
    v(1,0,0,0,0,0, 1,1,5);
    v(1,0,0,0,0,0, 1,1,5);
    v(1,0,0,0,0,0, 1,1,4);
    v(0,0,0,0,0,0, 0,0,4);
    v(1,1,1,0,0,0, 0,1,4);
    v(1,1,1,0,0,0, 0,1,4);
    v(1,1,0,0,0,0, 0,1,4);
    v(1,1,0,0,0,0, 1,1,12);
    for (int i = 28; i <= 31; i++) v(1,1,0,0,0,0, 1,1,12);
    v(1,1,0,0,0,0, 0,0,12);
    v(1,0,0,1,0,0, 1,1,13);
    v(1,0,0,0,0,0, 1,1,15);
    v(1,0,0,0,0,0, 1,1,14);
    v(0,0,0,0,0,0, 0,0,14);

    repeat (2) @(negedge clk);
    check("reset pulse", pulse, 0);
    check("reset busy", busy, 0);
    check("reset gray", tick_gray, 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].l, tbl[i].p, tbl[i].w);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d pulse", i), pulse, tbl[i].pu);
      check($sformatf("row%0d busy", i), busy, tbl[i].bu);
      check($sformatf("row%0d gray", i), tick_gray, tbl[i].g);
    end

    // Asynchronous reset in the middle of a long one-shot delay.
    drive(0,0,0,1,20,1);
    @(posedge clk); @(negedge clk);
    drive(1,1,1,0,0,0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("delay busy", busy, 1);
    drive(1,1,0,0,0,0);
    #2 rst = 1'b0;
    #1;
    check("async rst pulse", pulse, 0);
    check("async rst busy", busy, 0);
    check("async rst gray", tick_gray, 0);
    @(negedge clk);
    rst = 1'b1;

    // Default period is back after reset.
    drive(1,0,0,0,0,0);
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("default period pulse e%0d", i), pulse, (i % DEF_P) == 0);
    end
    check("default period gray", tick_gray, gray(3));
    drive(0,0,0,0,0,0);
    @(posedge clk); @(negedge clk);

    // Clamped P=1/W=1: one tick per edge, Gray steps flip a single bit and wrap.
    drive(1,0,0,1,0,0);
    prev_g = tick_gray;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      drive(1,0,0,0,0,0);
      check($sformatf("p1 pulse e%0d", i), pulse, 1);
      check($sformatf("p1 gray e%0d", i), tick_gray, gray(4 + i));
      check($sformatf("p1 onebit e%0d", i), $countones(tick_gray ^ TICK_W'(prev_g)), 1);
      prev_g = tick_gray;
    end

    // Randomized run against the reference model.
    drive(0,0,0,0,0,0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 6), $urandom_range(0, 7));
      @(posedge clk);
      model_edge(en, mode, start, period_ld, int'(period_in), int'(width_in));
      @(negedge clk);
      check($sformatf("rand%0d pulse", i), pulse, exp_pulse());
      check($sformatf("rand%0d busy", i), busy, m_state != 0);
      check($sformatf("rand%0d gray", i), tick_gray, gray(m_tick));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_tick_gen.md
Name: pulse_tick_gen

Overview:
Parametrised, runtime-programmable pulse/tick generator. It is the next generation of the fixed 1 Hz single-cycle pulse source that drives the Gray counter datapath. It adds a loadable period and pulse width, a periodic or one-shot mode, an enable/abort control, a busy flag, and a Gray-coded count of emitted pulses. It feeds enable ticks to the Gray counter stages and the display logic.

Parameters:
CNT_W, 27, width of period counter and period register (must hold DEFAULT_PERIOD).
DEFAULT_PERIOD, 100000000, reset value of period P in clk cycles (1 s at 10 ns clock); must be >= 1.
PW_W, 4, width of pulse-width register.
TICK_W, 4, width of Gray-coded pulse count output.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
en  input  1  global enable; low forces IDLE from any state (abort).
mode  input  1  0 = periodic, 1 = one-shot; sampled only in IDLE.
start  input  1  one-shot trigger; used only when mode=1, en=1, IDLE.
period_ld  input  1  load strobe for period_in/width_in.
period_in  input  CNT_W  new period P; 0 is clamped to 1.
width_in  input  PW_W  new pulse width W; 0 is clamped to 1.
pulse  output  1  registered pulse output.
busy  output  1  high whenever state != IDLE.
tick_gray  output  TICK_W  Gray code of binary count of pulse rising edges.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, pulse=0, busy=0, tick count=0, tick_gray=0, active P=DEFAULT_PERIOD, active W=1, shadow regs = active values.
- All outputs are registered. All timing below is counted in rising edges of clk.
- States: IDLE, RUN (periodic), DELAY and PULSE (one-shot).
- IDLE -> RUN: mode=0 and en=1 sampled at edge k.
  - pulse rises at edge k, then again at k+P, k+2P, ...
  - Each pulse stays high min(W,P) cycles. If W >= P, pulse stays continuously high, but a boundary still occurs every P cycles.
  - cnt runs 0..P-1 and wraps. The wrap edge is the "period boundary".
- IDLE -> DELAY: mode=1, en=1, start=1 sampled at edge k. busy rises at edge k.
  - DELAY -> PULSE at edge k+P, where pulse rises.
  - PULSE -> IDLE at edge k+P+W: pulse and busy fall together.
  - start is ignored outside IDLE. Re-trigger is only accepted after return to IDLE.
- en=0 in any non-IDLE state: next edge gives IDLE, pulse=0, busy=0, cnt=0. tick count is retained.
- IDLE with mode=0: start is ignored. IDLE with en=0: start is ignored.
- Tick count: increments by 1 on every pulse rising event, i.e. every RUN boundary including the first, and every DELAY->PULSE transition.
  - In RUN with W >= P, it still increments at each boundary even though pulse does not toggle.
  - tick_gray = bin ^ (bin >> 1), registered and updated on the same edge as the pulse rise.
  - Wraps from 2^TICK_W-1 to 0; for TICK_W=4, 1000 -> 0000.
- period_ld sampled at an edge: shadow P/W <= clamped inputs.
  - In IDLE: active regs update on the same edge.
  - In RUN: active <= shadow at the next period boundary edge, and the new period uses the new values.
  - In DELAY/PULSE: applied on return to IDLE; the in-flight one-shot is unaffected.
  - Multiple loads before application: last one wins.
  - period_ld coincident with a boundary: the new values are applied at that boundary.
- Mode changes outside IDLE are ignored.
- Reset mid-operation: immediate return to reset values, including P/W. Loaded values are lost.

Test Plan:
- DEFAULT_PERIOD=5, reset released, en=1, mode=0 from edge 0 -> pulse high 1 cycle at edges 0,5,10,15; tick_gray 1,3,2,6; busy=1.
- period_ld with period_in=3, width_in=2 in IDLE, then en=1 at edge 0 -> pulse high edges 0-1, 3-4, 6-7; load width_in=5 mid-run -> pulse constantly high from the next boundary while tick_gray still advances every 3 cycles.
- mode=1, P=4, W=2, start at edge 10 -> busy rises at 10, pulse high edges 14-15, pulse and busy fall at 16; a second start at edge 12 is ignored; tick count +1 only.
- en dropped at edge 7 during RUN (P=5) -> pulse=0, busy=0 after edge 7; re-enable at 12 -> pulse rises at edge 12; tick count continues from its held value.
- TICK_W=4, P=1, W=1, periodic -> pulse continuously high; tick_gray steps 0001,0011,0010,... and wraps 1000->0000 after 16 edges; exactly one bit changes per step.
- rst asserted mid-DELAY with P=20 loaded -> outputs 0 immediately (asynchronously); after release, a new run uses P=DEFAULT_PERIOD; period_in=0 load -> P=1 (clamp).
